// File: rtl/seq_div8by4.sv
// Sequential 8/4 unsigned restoring divider, one quotient bit per clock, start/busy/done handshake.
// Optional DIV_SELFCHECK_EN adds chk_err, a q*b+r==a / r<b consistency flag on each result.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | waiting for start
// S_RUN  | iterating, one quotient bit per cycle (busy=1)
// S_DONE | one-cycle result strobe (done=1), may accept a new start
module seq_div8by4 (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] a,
  input  logic [3:0] b,
  output logic       busy,
  output logic       done,
  output logic [7:0] q,
  output logic [3:0] r,
`ifdef DIV_SELFCHECK_EN
  output logic       dz,
  output logic       chk_err
`else
  output logic       dz
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [4:0] rem_q, rem_d;
  logic [7:0] qsr_q, qsr_d;
  logic [2:0] cnt_q, cnt_d;
  logic [3:0] b_q, b_d;
  logic [7:0] q_q, q_d;
  logic [3:0] r_q, r_d;
  logic       dz_q, dz_d;

  logic [4:0] rem_sh;
  logic       fits;
  logic [4:0] rem_nx;
  logic [7:0] qsr_nx;

`ifdef DIV_SELFCHECK_EN
  logic [7:0]  a_q, a_d;
  logic        chk_q, chk_d;
  logic [11:0] chk_sum;
  logic        chk_bad;
`endif

  // One restoring step: shift in the next dividend bit, subtract when it fits.
  always_comb begin
    rem_sh = {rem_q[3:0], qsr_q[7]};
    fits   = (rem_sh >= {1'b0, b_q});
    rem_nx = fits ? (rem_sh - {1'b0, b_q}) : rem_sh;
    qsr_nx = {qsr_q[6:0], fits};
  end

`ifdef DIV_SELFCHECK_EN
  always_comb begin
    chk_sum = ({4'b0000, qsr_nx} * {8'b0000_0000, b_q}) + {8'b0000_0000, rem_nx[3:0]};
    chk_bad = (chk_sum != {4'b0000, a_q}) || (rem_nx[3:0] >= b_q);
  end
`endif

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    qsr_d   = qsr_q;
    cnt_d   = cnt_q;
    b_d     = b_q;
    q_d     = q_q;
    r_d     = r_q;
    dz_d    = dz_q;
`ifdef DIV_SELFCHECK_EN
    a_d     = a_q;
    chk_d   = 1'b0;
`endif

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          b_d = b;
`ifdef DIV_SELFCHECK_EN
          a_d = a;
`endif
          if (b != 4'd0) begin
            state_d = S_RUN;
            rem_d   = 5'd0;
            qsr_d   = a;
            cnt_d   = 3'd7;
          end else begin
            state_d = S_DONE;
            q_d     = 8'hFF;
            r_d     = 4'hF;
            dz_d    = 1'b1;
          end
        end
      end

      S_RUN: begin
        rem_d = rem_nx;
        qsr_d = qsr_nx;
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd0) begin
          state_d = S_DONE;
          q_d     = qsr_nx;
          r_d     = rem_nx[3:0];
          dz_d    = 1'b0;
`ifdef DIV_SELFCHECK_EN
          chk_d   = chk_bad;
`endif
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      rem_q   <= 5'd0;
      qsr_q   <= 8'd0;
      cnt_q   <= 3'd0;
      b_q     <= 4'd0;
      q_q     <= 8'd0;
      r_q     <= 4'd0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      qsr_q   <= qsr_d;
      cnt_q   <= cnt_d;
      b_q     <= b_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dz_q    <= dz_d;
    end
  end

`ifdef DIV_SELFCHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= 8'd0;
      chk_q <= 1'b0;
    end else begin
      a_q   <= a_d;
      chk_q <= chk_d;
    end
  end

  assign chk_err = chk_q;
`endif

  // busy/done decode straight from the state flops, so no input reaches an output combinationally.
  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign q    = q_q;
  assign r    = r_q;
  assign dz   = dz_q;

endmodule

// File: tb/tb_seq_div8by4.sv
// Directed self-checking bench for seq_div8by4: reset, result table, divide-by-zero,
// ignored start while busy, back-to-back accept from DONE, and reset during an operation.
module tb_seq_div8by4;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [3:0] b;
  logic       busy;
  logic       done;
  logic [7:0] q;
  logic [3:0] r;
  logic       dz;
`ifdef DIV_SELFCHECK_EN
  logic       chk_err;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  seq_div8by4 dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .q       (q),
    .r       (r),
`ifdef DIV_SELFCHECK_EN
    .dz      (dz),
    .chk_err (chk_err)
`else
    .dz      (dz)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts cycles from the current one (inclusive) until done is seen; bounded.
  task automatic wait_done(output int lat, output int bcnt, output bit ovl);
    lat  = 0;
    bcnt = 0;
    ovl  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      lat++;
      if (busy) bcnt++;
      if (busy && done) ovl = 1'b1;
      if (done) break;
      @(posedge clk); #1;
    end
    if (!done) lat = 99;
  endtask

  // Issue one request (called #1 after a posedge); returns #1 into the done cycle.
  task automatic run_op(input logic [7:0] ai, input logic [3:0] bi,
                        output int lat, output int bcnt, output bit ovl);
    start = 1'b1; a = ai; b = bi;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat, bcnt, ovl);
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; a = 8'd0; b = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({busy, done, q, r, dz} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%0b done=%0b q=%0d r=%0d dz=%0b, want all 0", busy, done, q, r, dz);
    end
`ifdef DIV_SELFCHECK_EN
    n_tests++;
    if (chk_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_chk_err: got %0b want 0", chk_err);
    end
`endif
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_table;
    logic [7:0] va [6] = '{8'd200, 8'd255, 8'd255, 8'd5, 8'd0, 8'd15};
    logic [3:0] vb [6] = '{4'd7,   4'd1,   4'd15,  4'd9, 4'd5, 4'd15};
    logic [7:0] vq [6] = '{8'd28,  8'd255, 8'd17,  8'd0, 8'd0, 8'd1};
    logic [3:0] vr [6] = '{4'd4,   4'd0,   4'd0,   4'd5, 4'd0, 4'd0};
    int lat, bcnt;
    bit ovl;
    for (int i = 0; i < 6; i++) begin
      run_op(va[i], vb[i], lat, bcnt, ovl);
      n_tests++;
      if (lat !== 9 || bcnt !== 8 || ovl !== 1'b0) begin
        n_fail++;
        $display("FAIL table_timing[%0d]: got latency=%0d busy_cycles=%0d overlap=%0b, want 9/8/0", i, lat, bcnt, ovl);
      end
      n_tests++;
      if (q !== vq[i] || r !== vr[i] || dz !== 1'b0) begin
        n_fail++;
        $display("FAIL table_result[%0d] %0d/%0d: got q=%0d r=%0d dz=%0b, want q=%0d r=%0d dz=0", i, va[i], vb[i], q, r, dz, vq[i], vr[i]);
      end
`ifdef DIV_SELFCHECK_EN
      n_tests++;
      if (chk_err !== 1'b0) begin
        n_fail++;
        $display("FAIL table_chk_err[%0d]: got %0b want 0", i, chk_err);
      end
`endif
      @(posedge clk); #1;
      n_tests++;
      if (done !== 1'b0 || q !== vq[i] || r !== vr[i]) begin
        n_fail++;
        $display("FAIL table_hold[%0d]: got done=%0b q=%0d r=%0d, want done=0 q=%0d r=%0d", i, done, q, r, vq[i], vr[i]);
      end
    end
  endtask

  task automatic test_div_zero;
    int lat, bcnt;
    bit ovl;
    run_op(8'd100, 4'd0, lat, bcnt, ovl);
    n_tests++;
    if (lat !== 1 || bcnt !== 0) begin
      n_fail++;
      $display("FAIL dz_timing: got latency=%0d busy_cycles=%0d, want 1/0", lat, bcnt);
    end
    n_tests++;
    if (q !== 8'hFF || r !== 4'hF || dz !== 1'b1) begin
      n_fail++;
      $display("FAIL dz_result: got q=%0h r=%0h dz=%0b, want q=ff r=f dz=1", q, r, dz);
    end
`ifdef DIV_SELFCHECK_EN
    n_tests++;
    if (chk_err !== 1'b0) begin
      n_fail++;
      $display("FAIL dz_chk_err: got %0b want 0", chk_err);
    end
`endif
    @(posedge clk); #1;
    n_tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL dz_after: got done=%0b busy=%0b, want 0/0", done, busy);
    end
  endtask

  task automatic test_ignore_start;
    int lat, bcnt;
    bit ovl;
    start = 1'b1; a = 8'd200; b = 4'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    start = 1'b1; a = 8'd9; b = 4'd3;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat, bcnt, ovl);
    n_tests++;
    if (lat !== 5 || bcnt !== 4) begin
      n_fail++;
      $display("FAIL ignore_timing: got remaining=%0d busy=%0d, want 5/4", lat, bcnt);
    end
    n_tests++;
    if (q !== 8'd28 || r !== 4'd4 || dz !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_result: got q=%0d r=%0d dz=%0b, want 28/4/0", q, r, dz);
    end
  endtask

  // Enters from the done cycle of the previous test (q=28, r=4).
  task automatic test_back_to_back;
    int lat, bcnt;
    bit ovl;
    start = 1'b1; a = 8'd9; b = 4'd3;
    @(posedge clk); #1;
    start = 1'b0;
    n_tests++;
    if (busy !== 1'b1 || done !== 1'b0 || q !== 8'd28 || r !== 4'd4) begin
      n_fail++;
      $display("FAIL b2b_first_cycle: got busy=%0b done=%0b q=%0d r=%0d, want 1/0/28/4", busy, done, q, r);
    end
    repeat (4) begin @(posedge clk); #1; end
    n_tests++;
    if (q !== 8'd28 || r !== 4'd4) begin
      n_fail++;
      $display("FAIL b2b_hold: got q=%0d r=%0d, want 28/4", q, r);
    end
    wait_done(lat, bcnt, ovl);
    n_tests++;
    if (lat !== 5 || ovl !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_timing: got remaining=%0d overlap=%0b, want 5/0", lat, ovl);
    end
    n_tests++;
    if (q !== 8'd3 || r !== 4'd0 || dz !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_result: got q=%0d r=%0d dz=%0b, want 3/0/0", q, r, dz);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midop;
    int lat, bcnt;
    bit ovl;
    bit saw_done;
    start = 1'b1; a = 8'd200; b = 4'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    n_tests++;
    if ({busy, done, q, r, dz} !== 15'd0) begin
      n_fail++;
      $display("FAIL midrst_outputs: got busy=%0b done=%0b q=%0d r=%0d dz=%0b, want all 0", busy, done, q, r, dz);
    end
    saw_done = 1'b0;
    repeat (2) begin @(posedge clk); #1; if (done) saw_done = 1'b1; end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin @(posedge clk); #1; if (done || busy) saw_done = 1'b1; end
    n_tests++;
    if (saw_done !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_no_done: got activity=%0b want 0", saw_done);
    end
    run_op(8'd64, 4'd8, lat, bcnt, ovl);
    n_tests++;
    if (lat !== 9 || q !== 8'd8 || r !== 4'd0 || dz !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_after: got latency=%0d q=%0d r=%0d dz=%0b, want 9/8/0/0", lat, q, r, dz);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_table();
    test_div_zero();
    test_ignore_start();
    test_back_to_back();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_div8by4.md
# seq_div8by4

Sequential unsigned divider: 8-bit dividend by 4-bit divisor, producing an 8-bit quotient and a 4-bit remainder. It uses a restoring shift-subtract algorithm, one quotient bit per clock. It is the inverse companion of the team's 4x4 multiplier datapath and covers the same operand widths (8-bit product ↔ 8-bit dividend, 4-bit factor ↔ 4-bit divisor). Operations use a start/busy/done handshake.

## Interface
- No parameters; widths fixed (dividend 8, divisor 4).
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled on rising clk while busy=0
- a  input  8  dividend, captured when start accepted
- b  input  4  divisor, captured when start accepted
- busy  output  1  high while iterating (RUN state)
- done  output  1  single-cycle pulse; q/r/dz valid from this cycle
- q  output  8  quotient, registered, held until next completion
- r  output  4  remainder, registered, held until next completion
- dz  output  1  divide-by-zero flag for the last completed operation
- chk_err  output  1  present only with DIV_SELFCHECK_EN (see Configuration)

## Operation
- States: IDLE, RUN, DONE.
- IDLE/DONE with start=1 → capture a, b.
  - b≠0: next state RUN. Working remainder (5 bits) = 0, quotient shift register = a, bit counter = 7.
  - b=0: next state DONE directly.
- RUN, per cycle (MSB first): rem = {rem[3:0], qsr[7]}; qsr <<= 1. If rem ≥ {1'b0,b}, then rem -= b and qsr[0] = 1; otherwise qsr[0] = 0. Decrement the counter.
- RUN with counter=0 after the iteration → DONE. Load q=qsr, r=rem[3:0], dz=0.
- Divide-by-zero path → DONE. Load q=8'hFF, r=4'hF, dz=1.
- DONE lasts one cycle, with done=1. Next state is IDLE, or RUN/DONE if start is accepted in that cycle (back-to-back allowed).
- start while busy=1 is ignored. No queuing.
- q, r, dz change only on entry to DONE. They hold their values through later RUN cycles.
- Arithmetic is unsigned. Invariant for b≠0: q*b + r == a, r < b.

## Timing
- Reset (async assert, any state): state=IDLE, busy=0, done=0, q=0, r=0, dz=0, chk_err=0, internal registers 0. An in-flight operation is discarded and no done is produced.
- Accept edge = E0.
  - b≠0: busy=1 for cycles after E0 through E8. done=1 in the cycle after E8 (the 9th cycle). Latency is 9 clocks from accept to done.
  - b=0: done=1 in the cycle after E0. busy stays 0.
- busy and done are never high together.
- Accepting start in a DONE cycle gives busy=1 in the next cycle. Throughput is one result per 9 clocks.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- Macro: DIV_SELFCHECK_EN.
- Defined:
  - Port chk_err exists.
  - On entry to DONE with dz=0, the block computes q*{4'b0,b} + r (12 bits) and compares it with the captured a.
  - chk_err=1 for the DONE cycle only, when the values mismatch or r ≥ b.
  - chk_err is 0 when dz=1.
  - Reset value is 0.
- Undefined: port chk_err and all check logic are absent. Behaviour is otherwise identical.

## Test plan
- a=200, b=7, start for 1 cycle → busy high 8 cycles, then done pulse with q=28, r=4, dz=0 (chk_err=0 if enabled).
- a=255, b=1 → q=255, r=0. Then a=255, b=15 → q=17, r=0. Then a=5, b=9 → q=0, r=5.
- a=100, b=0 → done in the cycle after accept, busy never high, q=8'hFF, r=4'hF, dz=1.
- Accept a=200, b=7; pulse start with a=9, b=3 during the 4th busy cycle → it is ignored; result is still q=28, r=4.
- Assert start in the DONE cycle with a=9, b=3 → busy next cycle, second done 9 clocks later with q=3, r=0. First result held until then.
- Assert rst during the 5th busy cycle → all outputs 0 immediately, no done pulse. After release, a=64, b=8 → q=8, r=0.
